// File: rtl/roller_pingpong.sv
// Two-bank width reducer: a NUM-element vector is emitted as NUM/ROLL_NUM beats of ROLL_NUM elements.
// Optional macro ROLLER_PINGPONG_FLUSH_EN adds a flush input that empties both banks.
module roller_pingpong #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM        = 8,
  parameter  int ROLL_NUM   = 2,
  localparam int CYCLES     = NUM / ROLL_NUM,
  localparam int BW         = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [ROLL_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
`ifdef ROLLER_PINGPONG_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  data_out_last,
  output logic [BW-1:0]         data_out_beat
);

  localparam int CW = $clog2(CYCLES + 1);

  if (NUM % ROLL_NUM != 0) begin : g_bad_cfg
    $error("roller_pingpong: NUM must be a multiple of ROLL_NUM");
  end
  if (ROLL_NUM < 1 || ROLL_NUM > NUM) begin : g_bad_roll
    $error("roller_pingpong: ROLL_NUM must be in 1..NUM");
  end

  logic [DATA_WIDTH-1:0] bank [2][NUM];
  logic [CW-1:0]         cnt [2];
  logic                  wr_sel;
  logic                  rd_sel;
  logic [CW-1:0]         cnt_rd;
  logic [CW-1:0]         k_c;
  logic [BW-1:0]         beat_k;
  logic                  load;
  logic                  drain;
  logic                  do_flush;

`ifdef ROLLER_PINGPONG_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Handshake/status decode: everything here comes from registers, except that
  // flush masks data_in_ready so a load offered during a flush is never taken.
  always_comb begin
    cnt_rd         = cnt[rd_sel];
    data_out_valid = (cnt_rd != '0);
    data_in_ready  = (cnt[wr_sel] == '0) && !do_flush;
    load           = data_in_valid && data_in_ready;
    drain          = data_out_valid && data_out_ready;
    k_c            = CW'(CYCLES) - cnt_rd;
    beat_k         = data_out_valid ? BW'(k_c) : '0;
    data_out_beat  = beat_k;
    data_out_last  = data_out_valid && (cnt_rd == CW'(1));
    for (int i = 0; i < ROLL_NUM; i++) data_out[i] = '0;
    for (int b = 0; b < CYCLES; b++) begin
      if (beat_k == BW'(b)) begin
        for (int i = 0; i < ROLL_NUM; i++) data_out[i] = bank[rd_sel][b*ROLL_NUM + i];
      end
    end
  end

  // Load and drain never hit the same busy bank, so both may update on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < NUM; e++) bank[b][e] <= '0;
      end
    end else if (do_flush) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (load) begin
        for (int e = 0; e < NUM; e++) bank[wr_sel][e] <= data_in[e];
        cnt[wr_sel] <= CW'(CYCLES);
        wr_sel      <= ~wr_sel;
      end
      if (drain) begin
        cnt[rd_sel] <= cnt_rd - CW'(1);
        if (cnt_rd == CW'(1)) rd_sel <= ~rd_sel;
      end
    end
  end

endmodule

// File: doc/roller_pingpong.md
Name: roller_pingpong

Overview:
- Parametrised successor to the single-buffer width-reducing roller.
- Accepts a NUM-element vector in one handshake and emits it as NUM/ROLL_NUM consecutive ROLL_NUM-element beats.
- Two banks (ping-pong), so the next vector loads while the current one drains: full throughput, no bubble between vectors.
- Sits between conv/linear datapath stages whose parallelism differs, e.g. after im2col before a narrower MAC array.

Parameters:
- DATA_WIDTH, 16, bits per element.
- NUM, 8, elements per input vector; NUM % ROLL_NUM == 0 required (elaboration-time check, $error).
- ROLL_NUM, 2, elements per output beat; 1 <= ROLL_NUM <= NUM.
- Derived CYCLES = NUM/ROLL_NUM (beats per vector).
- Derived BW = max(1, $clog2(CYCLES)) (beat-index width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH x NUM (unpacked [NUM-1:0])  input vector
- data_in_valid  in  1  input handshake valid
- data_in_ready  out  1  a bank is free
- data_out  out  DATA_WIDTH x ROLL_NUM (unpacked [ROLL_NUM-1:0])  current beat
- data_out_valid  out  1  beat valid
- data_out_ready  in  1  downstream accepts beat
- data_out_last  out  1  current beat is final beat of its vector
- data_out_beat  out  BW  index of current beat within vector (0..CYCLES-1)

Behaviour:
- State:
  - bank[0..1] of NUM elements.
  - cnt[0..1] holds beats remaining (0..CYCLES); width $clog2(CYCLES+1).
  - wr_sel, rd_sel are 1-bit.
- Reset: cnt=0, wr_sel=rd_sel=0, banks zeroed. Resulting outputs: data_in_ready=1, data_out_valid=0, data_out_last=0, data_out_beat=0, data_out all zeros.
- data_in_ready = (cnt[wr_sel]==0).
  - Derived from registers only; no combinational path from data_out_ready or data_in_valid.
- Load (data_in_valid && data_in_ready):
  - bank[wr_sel] <= data_in.
  - cnt[wr_sel] <= CYCLES.
  - wr_sel toggles.
- data_out_valid = (cnt[rd_sel]!=0).
- Beat k = CYCLES - cnt[rd_sel].
  - data_out[i] = bank[rd_sel][k*ROLL_NUM+i], i.e. element order preserved: beat 0 carries elements 0..ROLL_NUM-1.
  - data_out_beat = k.
  - data_out_last = valid && cnt[rd_sel]==1.
- Drain (data_out_valid && data_out_ready):
  - cnt[rd_sel] decrements.
  - When it reaches 0, rd_sel toggles on the same edge.
- Simultaneous load and drain:
  - They always target different banks, or the same bank only when it is free: load overwrites the freed bank.
  - Both updates apply on the same edge.
- Latency: vector accepted at edge N gives first beat valid after edge N (cycle N+1), when the other bank is empty.
- Throughput: one beat per cycle sustained with data_out_ready=1, including CYCLES==1 (pass-through, 1-cycle latency).
- Backpressure: while valid && !ready, data_out, data_out_beat and data_out_last hold stable.
- Full: both cnt non-zero gives data_in_ready=0.
  - Final drain handshake of rd_sel bank frees it; data_in_ready=1 the next cycle.
- Empty: both cnt zero gives data_out_valid=0; data_out shows the stale bank contents (don't-care).
- Reset mid-operation: all buffered vectors discarded; returns to the reset state next cycle.

Optional Feature:
- Macro ROLLER_PINGPONG_FLUSH_EN.
- When defined, adds input port `flush` (1 bit, after data_out_ready).
- flush=1 on an edge:
  - cnt[0..1] <= 0, wr_sel=rd_sel=0.
  - Bank contents are not cleared.
  - data_in_ready forced 0 that cycle, so no load is lost silently.
  - Any same-cycle output handshake counts as delivered, but its state update is overridden.
- When undefined: port absent, no flush logic.

Test Plan (NUM=8, ROLL_NUM=2, CYCLES=4):
- Single vector: load {0..7} with downstream ready.
  - Beats {0,1},{2,3},{4,5},{6,7} on cycles N+1..N+4.
  - data_out_beat 0..3; data_out_last only on {6,7}.
  - data_in_ready stays 1.
- Back-to-back: 3 vectors {0..7},{10..17},{20..27} offered continuously, ready=1.
  - 12 consecutive valid beats, no bubble.
  - data_in_ready low only while both banks hold data.
- Backpressure:
  - ready=0 for 5 cycles mid-vector at beat 1: {2,3} held stable.
  - A second vector loads, then data_in_ready=0 until the first vector's last beat is accepted.
- Pass-through config NUM=ROLL_NUM=4: stream {1,2,3,4},{5,6,7,8} gives one beat per cycle, last=1 on every beat, beat=0.
- Reset mid-vector after beat {2,3} then immediately load {40..47}: the next output is {40,41}, beat=0, with no stale beats.
- With ROLLER_PINGPONG_FLUSH_EN: flush while both banks are full.
  - Next cycle valid=0, ready=1.
  - Next load {50..57} emits {50,51} first.
